// File: rtl/dcache_if.sv
// Data-cache request bus shared by the MEM-stage access controller and the
// data cache.
//   dcache_read / dcache_write : request flags, held until dcache_resp
//   dcache_address             : word-aligned request address
//   dcache_wdata / dcache_mbe  : store data and byte enables
//   dcache_rdata               : read data, valid with dcache_resp
//   dcache_resp                : one-cycle completion pulse
// master = requester (access controller), slave = cache.
interface dcache_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              dcache_read;
   logic              dcache_write;
   logic [ADDR_W-1:0] dcache_address;
   logic [31:0]       dcache_wdata;
   logic [3:0]        dcache_mbe;
   logic [31:0]       dcache_rdata;
   logic              dcache_resp;

   modport master (
      output dcache_read, dcache_write, dcache_address, dcache_wdata, dcache_mbe,
      input  dcache_rdata, dcache_resp
   );

   modport slave (
      input  dcache_read, dcache_write, dcache_address, dcache_wdata, dcache_mbe,
      output dcache_rdata, dcache_resp
   );
endinterface

// File: rtl/dcache_access_ctrl.sv
// MEM-stage data-cache access controller for the pipelined RV32I core.
// Turns one EX/MEM load/store into a single cache request (held until
// dcache_resp), stalls the pipeline while it is outstanding, formats store
// data/byte enables and aligns + extends load data.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   mem_valid          valid instruction in EX/MEM
//   dcache_read_i/_write_i, funct3  decoded control word
//   addr_i, store_data_i            effective address, rs2 value
//   pipe_advance       EX/MEM advances this cycle
//   dbus               cache request bus (master side)
//   load_data          extended load result (held until next load)
//   mem_stall          hold pipeline
//   misaligned         illegal or misaligned access (IDLE only)
//   bus_error          one-cycle pulse on request timeout
module dcache_access_ctrl #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_valid,
   input  logic              dcache_read_i,
   input  logic              dcache_write_i,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       store_data_i,
   input  logic              pipe_advance,
   dcache_if.master          dbus,
   output logic [31:0]       load_data,
   output logic              mem_stall,
   output logic              misaligned,
   output logic              bus_error
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t      state, state_nx;
   logic        acc, f3_ok, align_ok, legal, illegal;
   logic        resp_hit, tmo_hit;
   logic        is_load_q;
   logic [1:0]  off_q;
   logic [2:0]  f3_q;
   logic [31:0] cnt;

   // Align and extend the addressed byte/half of a cache read word.
   function automatic logic [31:0] extract(input logic [31:0] rdata,
                                           input logic [1:0]  off,
                                           input logic [2:0]  fn);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = rdata[7:0];
         2'd1:    b = rdata[15:8];
         2'd2:    b = rdata[23:16];
         default: b = rdata[31:24];
      endcase
      h = off[1] ? rdata[31:16] : rdata[15:0];
      case (fn)
         3'b000:  extract = {{24{b[7]}}, b};
         3'b100:  extract = {24'h0, b};
         3'b001:  extract = {{16{h[15]}}, h};
         3'b101:  extract = {16'h0, h};
         default: extract = rdata;
      endcase
   endfunction

   // Access decode
   always_comb begin
      acc = mem_valid & (dcache_read_i ^ dcache_write_i);
      case (funct3)
         3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
         3'b100, 3'b101:         f3_ok = dcache_read_i;   // unsigned forms exist only for loads
         default:                f3_ok = 1'b0;
      endcase
      case (funct3[1:0])
         2'b01:   align_ok = ~addr_i[0];
         2'b10:   align_ok = (addr_i[1:0] == 2'b00);
         default: align_ok = 1'b1;
      endcase
      legal    = acc & f3_ok & align_ok;
      illegal  = mem_valid & ((dcache_read_i & dcache_write_i) | (acc & ~(f3_ok & align_ok)));
      resp_hit = (state == S_BUSY) & dbus.dcache_resp;
      tmo_hit  = (TIMEOUT != 0) && (state == S_BUSY) && !dbus.dcache_resp
                 && (cnt == TIMEOUT - 1);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next state and combinational outputs
   always_comb begin
      state_nx   = state;
      mem_stall  = 1'b0;
      misaligned = 1'b0;
      case (state)
         S_IDLE: begin
            misaligned = illegal;
            if (legal) begin
               mem_stall = 1'b1;
               state_nx  = S_BUSY;
            end
         end
         S_BUSY: begin
            mem_stall = 1'b1;
            if (resp_hit || tmo_hit) state_nx = S_DONE;
         end
         S_DONE: begin
            if (pipe_advance) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
      // Keep combinational outputs quiet while reset is asserted.
      if (!rst_n) begin
         mem_stall  = 1'b0;
         misaligned = 1'b0;
      end
   end

   // Request, formatting and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dbus.dcache_read    <= 1'b0;
         dbus.dcache_write   <= 1'b0;
         dbus.dcache_address <= '0;
         dbus.dcache_wdata   <= '0;
         dbus.dcache_mbe     <= '0;
         load_data           <= '0;
         bus_error           <= 1'b0;
         is_load_q           <= 1'b0;
         off_q               <= '0;
         f3_q                <= '0;
         cnt                 <= '0;
      end else begin
         bus_error <= 1'b0;
         if (state == S_IDLE && legal) begin
            dbus.dcache_read    <= dcache_read_i;
            dbus.dcache_write   <= dcache_write_i;
            dbus.dcache_address <= {addr_i[ADDR_W-1:2], 2'b00};
            is_load_q           <= dcache_read_i;
            off_q               <= addr_i[1:0];
            f3_q                <= funct3;
            cnt                 <= '0;
            if (dcache_write_i) begin
               case (funct3[1:0])
                  2'b00: begin
                     dbus.dcache_wdata <= {4{store_data_i[7:0]}};
                     dbus.dcache_mbe   <= 4'b0001 << addr_i[1:0];
                  end
                  2'b01: begin
                     dbus.dcache_wdata <= {2{store_data_i[15:0]}};
                     dbus.dcache_mbe   <= 4'b0011 << addr_i[1:0];
                  end
                  default: begin
                     dbus.dcache_wdata <= store_data_i;
                     dbus.dcache_mbe   <= 4'b1111;
                  end
               endcase
            end else begin
               dbus.dcache_wdata <= '0;
               dbus.dcache_mbe   <= 4'b1111;
            end
         end else if (state == S_BUSY) begin
            cnt <= cnt + 32'd1;
            if (resp_hit) begin
               dbus.dcache_read  <= 1'b0;
               dbus.dcache_write <= 1'b0;
               if (is_load_q) load_data <= extract(dbus.dcache_rdata, off_q, f3_q);
            end else if (tmo_hit) begin
               dbus.dcache_read  <= 1'b0;
               dbus.dcache_write <= 1'b0;
               load_data         <= '0;
               bus_error         <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_dcache_access_ctrl.sv
module tb_dcache_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_valid, rd_i, wr_i, pipe_adv;
   logic [2:0]  f3;
   logic [31:0] addr, sdata;
   logic [31:0] ld0, ld1;
   logic        stall0, stall1, mis0, mis1, berr0, berr1;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   dcache_if #(.ADDR_W(32)) bus0 ();
   dcache_if #(.ADDR_W(32)) bus1 ();

   dcache_access_ctrl #(.ADDR_W(32), .TIMEOUT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid),
      .dcache_read_i(rd_i), .dcache_write_i(wr_i), .funct3(f3),
      .addr_i(addr), .store_data_i(sdata), .pipe_advance(pipe_adv),
      .dbus(bus0), .load_data(ld0), .mem_stall(stall0),
      .misaligned(mis0), .bus_error(berr0)
   );

   dcache_access_ctrl #(.ADDR_W(32), .TIMEOUT(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid),
      .dcache_read_i(rd_i), .dcache_write_i(wr_i), .funct3(f3),
      .addr_i(addr), .store_data_i(sdata), .pipe_advance(pipe_adv),
      .dbus(bus1), .load_data(ld1), .mem_stall(stall1),
      .misaligned(mis1), .bus_error(berr1)
   );

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_resp(input logic v, input logic [31:0] d);
      bus0.dcache_resp  = v;
      bus1.dcache_resp  = v;
      bus0.dcache_rdata = d;
      bus1.dcache_rdata = d;
   endtask

   task automatic clear_inputs();
      mem_valid = 1'b0; rd_i = 1'b0; wr_i = 1'b0; f3 = 3'b000;
      addr = 32'h0; sdata = 32'h0; pipe_adv = 1'b0;
   endtask

   // Drives one access on dut0 (dut1 follows in lockstep) and reports what was observed.
   task automatic run_access(input logic rd, input logic wr, input logic [2:0] fn,
                             input logic [31:0] a, input logic [31:0] sd,
                             input logic [31:0] rdat, input int lat,
                             output int rd_cyc, output int wr_cyc,
                             output logic [31:0] a_seen, output logic [3:0] mbe_seen,
                             output logic [31:0] wd_seen, output logic [31:0] ld,
                             output logic stall_issue, output logic stall_busy,
                             output logic stall_done, output logic both);
      rd_cyc = 0; wr_cyc = 0; a_seen = '0; mbe_seen = '0; wd_seen = '0;
      both = 1'b0; stall_busy = 1'b1;
      mem_valid = 1'b1; rd_i = rd; wr_i = wr; f3 = fn; addr = a; sdata = sd; pipe_adv = 1'b0;
      #1 stall_issue = stall0;
      for (int i = 1; i <= lat; i++) begin
         step();
         if (bus0.dcache_read)  rd_cyc++;
         if (bus0.dcache_write) wr_cyc++;
         if (bus0.dcache_read | bus0.dcache_write) begin
            a_seen = bus0.dcache_address; mbe_seen = bus0.dcache_mbe; wd_seen = bus0.dcache_wdata;
         end
         if (bus0.dcache_read & bus0.dcache_write) both = 1'b1;
         if (!stall0) stall_busy = 1'b0;
         if (i == lat) set_resp(1'b1, rdat);
      end
      step();
      set_resp(1'b0, 32'h0);
      if (bus0.dcache_read)  rd_cyc++;
      if (bus0.dcache_write) wr_cyc++;
      #1;
      ld = ld0;
      stall_done = stall0;
      pipe_adv = 1'b1;
      step();
      clear_inputs();
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      set_resp(1'b0, 32'h0);
      // a legal load presented during reset must not show through
      mem_valid = 1'b1; rd_i = 1'b1; f3 = 3'b010; addr = 32'h100;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      n_tests++;
      if ({bus0.dcache_read, bus0.dcache_write} !== 2'b00) begin
         n_fail++; $display("FAIL reset_req: got %b exp 00", {bus0.dcache_read, bus0.dcache_write});
      end
      n_tests++;
      if ({bus0.dcache_address, bus0.dcache_wdata, bus0.dcache_mbe} !== 68'h0) begin
         n_fail++; $display("FAIL reset_bus: addr %h wdata %h mbe %b exp zeros",
                            bus0.dcache_address, bus0.dcache_wdata, bus0.dcache_mbe);
      end
      n_tests++;
      if ({ld0, stall0, mis0, berr0} !== 35'h0) begin
         n_fail++; $display("FAIL reset_out: ld %h stall %b mis %b berr %b exp zeros", ld0, stall0, mis0, berr0);
      end
      clear_inputs();
      @(posedge clk); #2;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_lw();
      int rc, wc; logic [31:0] as, wd, ld; logic [3:0] mb; logic si, sb, sdn, bo;
      run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3,
                 rc, wc, as, mb, wd, ld, si, sb, sdn, bo);
      n_tests++; if (si !== 1'b1) begin n_fail++; $display("FAIL lw_stall_issue: got %b exp 1", si); end
      n_tests++; if (rc !== 3) begin n_fail++; $display("FAIL lw_read_cycles: got %0d exp 3", rc); end
      n_tests++; if (wc !== 0) begin n_fail++; $display("FAIL lw_write_cycles: got %0d exp 0", wc); end
      n_tests++; if (as !== 32'h100) begin n_fail++; $display("FAIL lw_addr: got %h exp 00000100", as); end
      n_tests++; if (mb !== 4'b1111) begin n_fail++; $display("FAIL lw_mbe: got %b exp 1111", mb); end
      n_tests++; if (sb !== 1'b1) begin n_fail++; $display("FAIL lw_stall_busy: got %b exp 1", sb); end
      n_tests++; if (ld !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h exp deadbeef", ld); end
      n_tests++; if (sdn !== 1'b0) begin n_fail++; $display("FAIL lw_stall_done: got %b exp 0", sdn); end
   endtask

   task automatic test_load_ext();
      logic [2:0]  fns  [7];
      logic [31:0] adrs [7];
      logic [31:0] exps [7];
      int rc, wc; logic [31:0] as, wd, ld; logic [3:0] mb; logic si, sb, sdn, bo;
      fns[0] = 3'b000; adrs[0] = 32'h103; exps[0] = 32'hFFFFFF80;   // LB
      fns[1] = 3'b100; adrs[1] = 32'h103; exps[1] = 32'h00000080;   // LBU
      fns[2] = 3'b001; adrs[2] = 32'h102; exps[2] = 32'hFFFF8011;   // LH
      fns[3] = 3'b101; adrs[3] = 32'h102; exps[3] = 32'h00008011;   // LHU
      fns[4] = 3'b000; adrs[4] = 32'h100; exps[4] = 32'h00000033;   // LB
      fns[5] = 3'b001; adrs[5] = 32'h100; exps[5] = 32'h00002233;   // LH
      fns[6] = 3'b000; adrs[6] = 32'h101; exps[6] = 32'h00000022;   // LB
      for (int i = 0; i < 7; i++) begin
         run_access(1'b1, 1'b0, fns[i], adrs[i], 32'h0, 32'h80112233, 1,
                    rc, wc, as, mb, wd, ld, si, sb, sdn, bo);
         n_tests++;
         if (ld !== exps[i]) begin
            n_fail++; $display("FAIL load_ext[%0d]: got %h exp %h", i, ld, exps[i]);
         end
         n_tests++;
         if (as !== 32'h100) begin
            n_fail++; $display("FAIL load_addr[%0d]: got %h exp 00000100", i, as);
         end
      end
   endtask

   task automatic test_store();
      logic [2:0]  fns [4];
      logic [31:0] adrs[4], sds[4], exp_a[4], exp_wd[4];
      logic [3:0]  exp_m[4];
      int rc, wc; logic [31:0] as, wd, ld; logic [3:0] mb; logic si, sb, sdn, bo;
      fns[0] = 3'b000; adrs[0] = 32'h201; sds[0] = 32'h000000A5;
      exp_a[0] = 32'h200; exp_m[0] = 4'b0010; exp_wd[0] = 32'hA5A5A5A5;
      fns[1] = 3'b001; adrs[1] = 32'h202; sds[1] = 32'h1234BEEF;
      exp_a[1] = 32'h200; exp_m[1] = 4'b1100; exp_wd[1] = 32'hBEEFBEEF;
      fns[2] = 3'b010; adrs[2] = 32'h204; sds[2] = 32'h12345678;
      exp_a[2] = 32'h204; exp_m[2] = 4'b1111; exp_wd[2] = 32'h12345678;
      fns[3] = 3'b000; adrs[3] = 32'h203; sds[3] = 32'hFFFFFF77;
      exp_a[3] = 32'h200; exp_m[3] = 4'b1000; exp_wd[3] = 32'h77777777;
      for (int i = 0; i < 4; i++) begin
         run_access(1'b0, 1'b1, fns[i], adrs[i], sds[i], 32'h0, 2,
                    rc, wc, as, mb, wd, ld, si, sb, sdn, bo);
         n_tests++;
         if (wc !== 2 || rc !== 0 || bo !== 1'b0) begin
            n_fail++; $display("FAIL store_req[%0d]: wr %0d rd %0d both %b exp 2 0 0", i, wc, rc, bo);
         end
         n_tests++;
         if (as !== exp_a[i] || mb !== exp_m[i] || wd !== exp_wd[i]) begin
            n_fail++; $display("FAIL store_fmt[%0d]: addr %h mbe %b wdata %h exp %h %b %h",
                               i, as, mb, wd, exp_a[i], exp_m[i], exp_wd[i]);
         end
         n_tests++;
         if (si !== 1'b1 || sdn !== 1'b0) begin
            n_fail++; $display("FAIL store_stall[%0d]: issue %b done %b exp 1 0", i, si, sdn);
         end
      end
   endtask

   task automatic test_illegal();
      logic        rds[7], wrs[7];
      logic [2:0]  fns[7];
      logic [31:0] adrs[7];
      rds[0] = 0; wrs[0] = 1; fns[0] = 3'b001; adrs[0] = 32'h201;   // SH odd
      rds[1] = 1; wrs[1] = 0; fns[1] = 3'b011; adrs[1] = 32'h100;   // bad load funct3
      rds[2] = 1; wrs[2] = 0; fns[2] = 3'b010; adrs[2] = 32'h102;   // LW misaligned
      rds[3] = 1; wrs[3] = 1; fns[3] = 3'b010; adrs[3] = 32'h100;   // both flags
      rds[4] = 0; wrs[4] = 1; fns[4] = 3'b100; adrs[4] = 32'h100;   // SBU does not exist
      rds[5] = 1; wrs[5] = 0; fns[5] = 3'b110; adrs[5] = 32'h100;   // bad load funct3
      rds[6] = 1; wrs[6] = 0; fns[6] = 3'b001; adrs[6] = 32'h101;   // LH odd
      for (int i = 0; i < 7; i++) begin
         mem_valid = 1'b1; rd_i = rds[i]; wr_i = wrs[i]; f3 = fns[i]; addr = adrs[i];
         #1;
         n_tests++;
         if (mis0 !== 1'b1 || stall0 !== 1'b0) begin
            n_fail++; $display("FAIL illegal_flag[%0d]: mis %b stall %b exp 1 0", i, mis0, stall0);
         end
         step();
         n_tests++;
         if (bus0.dcache_read !== 1'b0 || bus0.dcache_write !== 1'b0 || mis0 !== 1'b1) begin
            n_fail++; $display("FAIL illegal_noreq[%0d]: rd %b wr %b mis %b exp 0 0 1",
                               i, bus0.dcache_read, bus0.dcache_write, mis0);
         end
         clear_inputs();
         #1;
      end
      // legal access and a bubble without flags must not raise the flag
      mem_valid = 1'b1; rd_i = 1'b1; f3 = 3'b010; addr = 32'h104;
      #1;
      n_tests++;
      if (mis0 !== 1'b0) begin n_fail++; $display("FAIL legal_flag: mis %b exp 0", mis0); end
      rd_i = 1'b0;
      #1;
      n_tests++;
      if (mis0 !== 1'b0 || stall0 !== 1'b0) begin
         n_fail++; $display("FAIL noflag_bubble: mis %b stall %b exp 0 0", mis0, stall0);
      end
      clear_inputs();
      #1;
   endtask

   task automatic test_back_to_back();
      int   rises = 0;
      logic prev  = 1'b0;
      mem_valid = 1'b1; rd_i = 1'b1; f3 = 3'b010; addr = 32'h300;
      #1;
      n_tests++; if (stall0 !== 1'b1) begin n_fail++; $display("FAIL b2b_stall1: got %b exp 1", stall0); end
      step();
      if (bus0.dcache_read & ~prev) rises++;
      prev = bus0.dcache_read;
      set_resp(1'b1, 32'h11111111);
      step();
      set_resp(1'b0, 32'h0);
      for (int i = 0; i < 2; i++) begin
         #1;
         if (bus0.dcache_read & ~prev) rises++;
         prev = bus0.dcache_read;
         n_tests++;
         if (ld0 !== 32'h11111111 || stall0 !== 1'b0 || bus0.dcache_read !== 1'b0) begin
            n_fail++; $display("FAIL b2b_hold[%0d]: ld %h stall %b rd %b exp 11111111 0 0",
                               i, ld0, stall0, bus0.dcache_read);
         end
         step();
      end
      pipe_adv = 1'b1;
      step();
      pipe_adv = 1'b0; addr = 32'h304;
      #1;
      n_tests++;
      if (stall0 !== 1'b1 || ld0 !== 32'h11111111) begin
         n_fail++; $display("FAIL b2b_issue2: stall %b ld %h exp 1 11111111", stall0, ld0);
      end
      step();
      if (bus0.dcache_read & ~prev) rises++;
      prev = bus0.dcache_read;
      n_tests++;
      if (bus0.dcache_address !== 32'h304 || ld0 !== 32'h11111111) begin
         n_fail++; $display("FAIL b2b_busy2: addr %h ld %h exp 00000304 11111111", bus0.dcache_address, ld0);
      end
      set_resp(1'b1, 32'h22222222);
      step();
      set_resp(1'b0, 32'h0);
      if (bus0.dcache_read & ~prev) rises++;
      n_tests++;
      if (ld0 !== 32'h22222222) begin n_fail++; $display("FAIL b2b_data2: got %h exp 22222222", ld0); end
      n_tests++;
      if (rises !== 2) begin n_fail++; $display("FAIL b2b_requests: got %0d exp 2", rises); end
      pipe_adv = 1'b1;
      step();
      clear_inputs();
      #1;
   endtask

   task automatic test_timeout();
      int rc, wc; logic [31:0] as, wd, ld; logic [3:0] mb; logic si, sb, sdn, bo;
      int rd1 = 0, be1 = 0, be_at = 0, be0 = 0;
      run_access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h55AA55AA, 1,
                 rc, wc, as, mb, wd, ld, si, sb, sdn, bo);
      n_tests++;
      if (ld1 !== 32'h55AA55AA) begin n_fail++; $display("FAIL tmo_preload: got %h exp 55aa55aa", ld1); end
      mem_valid = 1'b1; rd_i = 1'b1; f3 = 3'b010; addr = 32'h404;
      #1;
      for (int i = 1; i <= 8; i++) begin
         step();
         if (bus1.dcache_read) rd1++;
         if (berr1) begin be1++; be_at = i; end
         if (berr0) be0++;
      end
      n_tests++; if (rd1 !== 4) begin n_fail++; $display("FAIL tmo_req_cycles: got %0d exp 4", rd1); end
      n_tests++; if (be1 !== 1 || be_at !== 5) begin
         n_fail++; $display("FAIL tmo_bus_error: count %0d at %0d exp 1 at 5", be1, be_at);
      end
      n_tests++; if (ld1 !== 32'h0 || stall1 !== 1'b0) begin
         n_fail++; $display("FAIL tmo_done: ld %h stall %b exp 00000000 0", ld1, stall1);
      end
      n_tests++; if (bus0.dcache_read !== 1'b1 || be0 !== 0) begin
         n_fail++; $display("FAIL no_timeout: rd %b berr count %0d exp 1 0", bus0.dcache_read, be0);
      end
   endtask

   // Runs right after test_timeout, with dut0 still waiting in BUSY.
   task automatic test_reset_mid_busy();
      int rc, wc; logic [31:0] as, wd, ld; logic [3:0] mb; logic si, sb, sdn, bo;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (bus0.dcache_read !== 1'b0 || stall0 !== 1'b0) begin
         n_fail++; $display("FAIL rst_busy_drop: rd %b stall %b exp 0 0", bus0.dcache_read, stall0);
      end
      clear_inputs();
      step();
      rst_n = 1'b1;
      step();
      set_resp(1'b1, 32'hFFFFFFFF);
      step();
      set_resp(1'b0, 32'h0);
      #1;
      n_tests++;
      if (bus0.dcache_read !== 1'b0 || bus0.dcache_write !== 1'b0 || stall0 !== 1'b0 || ld0 !== 32'h0) begin
         n_fail++; $display("FAIL stray_resp: rd %b wr %b stall %b ld %h exp 0 0 0 00000000",
                            bus0.dcache_read, bus0.dcache_write, stall0, ld0);
      end
      run_access(1'b1, 1'b0, 3'b000, 32'h502, 32'h0, 32'h00C30000, 1,
                 rc, wc, as, mb, wd, ld, si, sb, sdn, bo);
      n_tests++;
      if (si !== 1'b1 || rc !== 1 || ld !== 32'hFFFFFFC3) begin
         n_fail++; $display("FAIL post_reset_load: stall %b rd %0d ld %h exp 1 1 ffffffc3", si, rc, ld);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_lw();
      test_load_ext();
      test_store();
      test_illegal();
      test_back_to_back();
      test_timeout();
      test_reset_mid_busy();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
